// File: rtl/id_scoreboard_if.sv
// id_scoreboard_if: ID-to-scoreboard issue bus plus scoreboard status.
//   master : ID stage side; drives decoded fields, writeback and load completion,
//            and observes id_ready and the status outputs.
//   slave  : scoreboard side.
//   CNT_W  : width of the stall counter.
interface id_scoreboard_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic             id_ready;
  logic             rs1_re;
  logic [4:0]       rs1_addr;
  logic             rs2_re;
  logic [4:0]       rs2_addr;
  logic             rd_we;
  logic [4:0]       rd_addr;
  logic             id_is_load;
  logic             flush;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic             ld_done;
  logic [31:0]      busy_vec;
  logic [3:0]       load_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             err;

  modport master (
    output id_valid, rs1_re, rs1_addr, rs2_re, rs2_addr, rd_we, rd_addr,
           id_is_load, flush, wb_valid, wb_addr, ld_done,
    input  id_ready, busy_vec, load_cnt, stall_cnt, err
  );

  modport slave (
    input  id_valid, rs1_re, rs1_addr, rs2_re, rs2_addr, rd_we, rd_addr,
           id_is_load, flush, wb_valid, wb_addr, ld_done,
    output id_ready, busy_vec, load_cnt, stall_cnt, err
  );
endinterface

// File: rtl/id_scoreboard.sv
// id_scoreboard: register scoreboard and issue gate between ID and execute.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   sb       : id_scoreboard_if slave port
//              id_ready is combinational (RAW/WAW/credit/flush gate);
//              busy_vec, load_cnt, stall_cnt and err are registered.
//   LOAD_MAX : maximum outstanding loads (1..15)
//   CNT_W    : stall counter width
module id_scoreboard #(
  parameter int unsigned LOAD_MAX = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  id_scoreboard_if.slave sb
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned LCW   = 4;

  logic [NREG-1:0]  busy_q, busy_d;
  logic [LCW-1:0]   load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;

  logic [NREG-1:0]  wb_clr;
  logic [NREG-1:0]  rd_set;
  logic [NREG-1:0]  eff_busy;
  logic             raw;
  logic             waw;
  logic             credit_block;
  logic             issue;
  logic             issue_load;

  // Hazard detection; a same-cycle writeback already resolves its register.
  always_comb begin
    wb_clr       = sb.wb_valid ? (NREG'(1) << sb.wb_addr) : '0;
    eff_busy     = busy_q & ~wb_clr;
    raw          = (sb.rs1_re && (sb.rs1_addr != 5'd0) && eff_busy[sb.rs1_addr]) ||
                   (sb.rs2_re && (sb.rs2_addr != 5'd0) && eff_busy[sb.rs2_addr]);
    waw          = sb.rd_we && (sb.rd_addr != 5'd0) && eff_busy[sb.rd_addr];
    // A load completing this cycle does not return its credit until the edge.
    credit_block = sb.id_is_load && (load_cnt_q == LCW'(LOAD_MAX));
    issue        = sb.id_valid && !sb.flush && !raw && !waw && !credit_block;
    issue_load   = issue && sb.id_is_load;
    rd_set       = (issue && sb.rd_we && (sb.rd_addr != 5'd0)) ?
                   (NREG'(1) << sb.rd_addr) : '0;
  end

  // Next-state: busy bits, load credits, stall counter, sticky error.
  always_comb begin
    busy_d      = busy_q;
    load_cnt_d  = load_cnt_q;
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;

    // Set applied after clear so an issuing writer keeps its register busy.
    busy_d    = (busy_q & ~wb_clr) | rd_set;
    busy_d[0] = 1'b0;

    unique case ({issue_load, sb.ld_done})
      2'b10:   load_cnt_d = load_cnt_q + LCW'(1);
      2'b01: begin
        if (load_cnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          load_cnt_d = load_cnt_q - LCW'(1);
        end
      end
      default: load_cnt_d = load_cnt_q;
    endcase

    // Writeback to a register nobody is writing.
    if (sb.wb_valid && (sb.wb_addr != 5'd0) && !busy_q[sb.wb_addr]) begin
      err_d = 1'b1;
    end

    if (sb.id_valid && !sb.flush && !issue && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      load_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      load_cnt_q  <= load_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign sb.id_ready  = issue;
  assign sb.busy_vec  = busy_q;
  assign sb.load_cnt  = load_cnt_q;
  assign sb.stall_cnt = stall_cnt_q;
  assign sb.err       = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed self-checking bench for id_scoreboard
// (LOAD_MAX=4, CNT_W=16).
module tb_id_scoreboard;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  id_scoreboard_if #(.CNT_W(16)) sb_if ();

  id_scoreboard #(.LOAD_MAX(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.id_valid   = 1'b0;
    sb_if.rs1_re     = 1'b0;
    sb_if.rs1_addr   = 5'd0;
    sb_if.rs2_re     = 1'b0;
    sb_if.rs2_addr   = 5'd0;
    sb_if.rd_we      = 1'b0;
    sb_if.rd_addr    = 5'd0;
    sb_if.id_is_load = 1'b0;
    sb_if.flush      = 1'b0;
    sb_if.wb_valid   = 1'b0;
    sb_if.wb_addr    = 5'd0;
    sb_if.ld_done    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    sb_if.id_valid = 1'b1;
    #12;
    checks++;
    if (sb_if.busy_vec !== 32'h0) begin
      errors++; $display("FAIL reset_busy: got %h exp %h", sb_if.busy_vec, 32'h0);
    end
    checks++;
    if (sb_if.load_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_load: got %0d exp 0", sb_if.load_cnt);
    end
    checks++;
    if (sb_if.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stall: got %0d exp 0", sb_if.stall_cnt);
    end
    checks++;
    if (sb_if.err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b exp 0", sb_if.err);
    end
    checks++;
    if (sb_if.id_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b exp 1", sb_if.id_ready);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    sb_if.id_valid = 1'b1; sb_if.rd_we = 1'b1; sb_if.rd_addr = 5'd5;
    #1;
    checks++;
    if (sb_if.id_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_issue: got %b exp 1", sb_if.id_ready);
    end
    step();
    checks++;
    if (sb_if.busy_vec !== 32'h0000_0020) begin
      errors++; $display("FAIL b2b_busy_set: got %h exp %h", sb_if.busy_vec, 32'h20);
    end
    sb_if.rd_we = 1'b0; sb_if.rd_addr = 5'd0;
    sb_if.rs1_re = 1'b1; sb_if.rs1_addr = 5'd5;
    #1;
    checks++;
    if (sb_if.id_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_raw_stall: got %b exp 0", sb_if.id_ready);
    end
    step();
    checks++;
    if (sb_if.stall_cnt !== 16'd1) begin
      errors++; $display("FAIL b2b_stall_cnt: got %0d exp 1", sb_if.stall_cnt);
    end
    sb_if.wb_valid = 1'b1; sb_if.wb_addr = 5'd5;
    #1;
    checks++;
    if (sb_if.id_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_wb_bypass: got %b exp 1", sb_if.id_ready);
    end
    step();
    idle();
    #1;
    checks++;
    if (sb_if.busy_vec !== 32'h0) begin
      errors++; $display("FAIL b2b_busy_clr: got %h exp %h", sb_if.busy_vec, 32'h0);
    end
    checks++;
    if (sb_if.stall_cnt !== 16'd1) begin
      errors++; $display("FAIL b2b_stall_hold: got %0d exp 1", sb_if.stall_cnt);
    end
    checks++;
    if (sb_if.err !== 1'b0) begin
      errors++; $display("FAIL b2b_err: got %b exp 0", sb_if.err);
    end
  endtask

  task automatic test_x0();
    sb_if.id_valid = 1'b1; sb_if.rd_we = 1'b1; sb_if.rd_addr = 5'd0;
    step();
    checks++;
    if (sb_if.busy_vec !== 32'h0) begin
      errors++; $display("FAIL x0_busy: got %h exp %h", sb_if.busy_vec, 32'h0);
    end
    sb_if.rd_we = 1'b0; sb_if.rs1_re = 1'b1; sb_if.rs1_addr = 5'd0;
    sb_if.rs2_re = 1'b1; sb_if.rs2_addr = 5'd0;
    #1;
    checks++;
    if (sb_if.id_ready !== 1'b1) begin
      errors++; $display("FAIL x0_read: got %b exp 1", sb_if.id_ready);
    end
    step();
    idle();
  endtask

  task automatic test_set_over_clear();
    sb_if.id_valid = 1'b1; sb_if.rd_we = 1'b1; sb_if.rd_addr = 5'd7;
    step();
    checks++;
    if (sb_if.busy_vec !== 32'h0000_0080) begin
      errors++; $display("FAIL soc_preload: got %h exp %h", sb_if.busy_vec, 32'h80);
    end
    sb_if.wb_valid = 1'b1; sb_if.wb_addr = 5'd7;
    #1;
    checks++;
    if (sb_if.id_ready !== 1'b1) begin
      errors++; $display("FAIL soc_waw_resolved: got %b exp 1", sb_if.id_ready);
    end
    step();
    idle();
    #1;
    checks++;
    if (sb_if.busy_vec !== 32'h0000_0080) begin
      errors++; $display("FAIL soc_set_wins: got %h exp %h", sb_if.busy_vec, 32'h80);
    end
    sb_if.wb_valid = 1'b1; sb_if.wb_addr = 5'd7;
    step();
    idle();
    #1;
    checks++;
    if (sb_if.busy_vec !== 32'h0) begin
      errors++; $display("FAIL soc_drain: got %h exp %h", sb_if.busy_vec, 32'h0);
    end
  endtask

  task automatic test_load_credits();
    sb_if.id_valid = 1'b1; sb_if.id_is_load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (sb_if.id_ready !== 1'b1) begin
        errors++; $display("FAIL ld_issue%0d: got %b exp 1", i, sb_if.id_ready);
      end
      step();
    end
    checks++;
    if (sb_if.load_cnt !== 4'd4) begin
      errors++; $display("FAIL ld_full: got %0d exp 4", sb_if.load_cnt);
    end
    sb_if.ld_done = 1'b1;
    #1;
    checks++;
    if (sb_if.id_ready !== 1'b0) begin
      errors++; $display("FAIL ld_credit_block: got %b exp 0", sb_if.id_ready);
    end
    step();
    sb_if.ld_done = 1'b0;
    #1;
    checks++;
    if (sb_if.load_cnt !== 4'd3) begin
      errors++; $display("FAIL ld_after_done: got %0d exp 3", sb_if.load_cnt);
    end
    checks++;
    if (sb_if.stall_cnt !== 16'd2) begin
      errors++; $display("FAIL ld_stall_cnt: got %0d exp 2", sb_if.stall_cnt);
    end
    checks++;
    if (sb_if.id_ready !== 1'b1) begin
      errors++; $display("FAIL ld_reissue: got %b exp 1", sb_if.id_ready);
    end
    step();
    idle();
    #1;
    checks++;
    if (sb_if.load_cnt !== 4'd4) begin
      errors++; $display("FAIL ld_refull: got %0d exp 4", sb_if.load_cnt);
    end
    sb_if.ld_done = 1'b1;
    for (int i = 0; i < 4; i++) step();
    idle();
    #1;
    checks++;
    if (sb_if.load_cnt !== 4'd0) begin
      errors++; $display("FAIL ld_drain: got %0d exp 0", sb_if.load_cnt);
    end
    checks++;
    if (sb_if.err !== 1'b0) begin
      errors++; $display("FAIL ld_no_err: got %b exp 0", sb_if.err);
    end
  endtask

  task automatic test_flush();
    sb_if.id_valid = 1'b1; sb_if.flush = 1'b1;
    sb_if.rd_we = 1'b1; sb_if.rd_addr = 5'd9; sb_if.id_is_load = 1'b1;
    #1;
    checks++;
    if (sb_if.id_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b exp 0", sb_if.id_ready);
    end
    step();
    idle();
    #1;
    checks++;
    if (sb_if.busy_vec !== 32'h0 || sb_if.load_cnt !== 4'd0) begin
      errors++; $display("FAIL flush_state: got busy=%h load=%0d exp busy=0 load=0",
                         sb_if.busy_vec, sb_if.load_cnt);
    end
    checks++;
    if (sb_if.stall_cnt !== 16'd2) begin
      errors++; $display("FAIL flush_stall: got %0d exp 2", sb_if.stall_cnt);
    end
  endtask

  task automatic test_errors();
    sb_if.ld_done = 1'b1;
    step();
    idle();
    #1;
    checks++;
    if (sb_if.err !== 1'b1 || sb_if.load_cnt !== 4'd0) begin
      errors++; $display("FAIL err_ld_underflow: got err=%b load=%0d exp err=1 load=0",
                         sb_if.err, sb_if.load_cnt);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (sb_if.err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b exp 1", sb_if.err);
    end
  endtask

  task automatic test_saturation_and_reset();
    sb_if.id_valid = 1'b1; sb_if.rd_we = 1'b1; sb_if.rd_addr = 5'd10;
    step();
    sb_if.rd_we = 1'b0; sb_if.rd_addr = 5'd0;
    sb_if.rs2_re = 1'b1; sb_if.rs2_addr = 5'd10;
    #1;
    checks++;
    if (sb_if.id_ready !== 1'b0) begin
      errors++; $display("FAIL sat_rs2_stall: got %b exp 0", sb_if.id_ready);
    end
    for (int i = 0; i < 65540; i++) step();
    checks++;
    if (sb_if.stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_value: got %h exp %h", sb_if.stall_cnt, 16'hFFFF);
    end
    checks++;
    if (sb_if.busy_vec !== 32'h0000_0400) begin
      errors++; $display("FAIL sat_busy: got %h exp %h", sb_if.busy_vec, 32'h400);
    end
    // Assert reset mid-cycle, well away from any edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sb_if.busy_vec !== 32'h0 || sb_if.load_cnt !== 4'd0 ||
        sb_if.stall_cnt !== 16'd0 || sb_if.err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got busy=%h load=%0d stall=%h err=%b exp all 0",
                         sb_if.busy_vec, sb_if.load_cnt, sb_if.stall_cnt, sb_if.err);
    end
    checks++;
    if (sb_if.id_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset_ready: got %b exp 1", sb_if.id_ready);
    end
    idle();
    @(negedge clk);
    rst = 1'b0;
    // Stale writeback from before reset.
    sb_if.wb_valid = 1'b1; sb_if.wb_addr = 5'd10;
    step();
    idle();
    #1;
    checks++;
    if (sb_if.err !== 1'b1) begin
      errors++; $display("FAIL err_stale_wb: got %b exp 1", sb_if.err);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_back_to_back();
    test_x0();
    test_set_over_clear();
    test_load_credits();
    test_flush();
    test_errors();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
